// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan multiplexer.
// Holds the hex-to-segment table, segment bit positions and the legal
// parameter ranges used by seg_scan_mux and seg_hex_decode.
package seg_pkg;

   // Bit position of each segment lamp inside a 7-bit segment word
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Legal parameter ranges
   localparam int DIGITS_MIN   = 2;
   localparam int DIGITS_MAX   = 8;
   localparam int PRESCALE_MIN = 2;
   localparam int PRESCALE_MAX = 1048576;

   // Active-high segment patterns, indexed by the hex value 0..F
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational 4-bit hex nibble to 7-segment pattern.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   logic [6:0] row_s;

   // Look up the table row, then route each lamp by its named bit position
   always_comb begin
      row_s           = HEX_SEG[nibble];
      segments        = 7'h00;
      segments[SEG_A] = row_s[SEG_A];
      segments[SEG_B] = row_s[SEG_B];
      segments[SEG_C] = row_s[SEG_C];
      segments[SEG_D] = row_s[SEG_D];
      segments[SEG_E] = row_s[SEG_E];
      segments[SEG_F] = row_s[SEG_F];
      segments[SEG_G] = row_s[SEG_G];
   end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a DIGITS-wide seven-segment
// display. New data lands in a shadow register and is only promoted to the
// display register at a frame boundary, so a frame never mixes old and new.
// Optional feature: define SEG_SCAN_LZ_BLANK_EN for leading-zero blanking.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int PRESCALE      = 50000,
   parameter int ANODE_ACT_LOW = 0
)(
   input  logic                  clk,
   input  logic                  res,
   input  logic [4*DIGITS-1:0]   data,
   input  logic                  load,
   input  logic [DIGITS-1:0]     blank,
   output logic [DIGITS-1:0]     anodes,
   output logic [6:0]            segments,
   output logic                  frame_done
);

   localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_OFF =
      (ANODE_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
      $error("seg_scan_mux: DIGITS out of range");
   end
   if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
      $error("seg_scan_mux: PRESCALE out of range");
   end

   logic [CW-1:0]         cnt_r;
   logic [IW-1:0]         idx_r;
   logic [4*DIGITS-1:0]   shadow_data_r;
   logic [DIGITS-1:0]     shadow_blank_r;
   logic [4*DIGITS-1:0]   disp_data_r;
   logic [DIGITS-1:0]     disp_blank_r;
   logic [DIGITS-1:0]     anodes_r;
   logic [6:0]            segments_r;
   logic                  frame_done_r;

   logic                  slot_end_s;
   logic                  wrap_s;
   logic [CW-1:0]         cnt_next_s;
   logic [IW-1:0]         idx_next_s;
   logic [4*DIGITS-1:0]   disp_data_next_s;
   logic [DIGITS-1:0]     disp_blank_next_s;
   logic [DIGITS-1:0]     eff_blank_s;
   logic [DIGITS-1:0]     an_act_s;
   logic [3:0]            nib_arr_s [DIGITS];
   logic [3:0]            nib_s;
   logic [6:0]            seg_dec_s;

   // Next-state of the slot timer, digit index and display register
   always_comb begin
      slot_end_s = (cnt_r == CNT_LAST);
      wrap_s     = slot_end_s && (idx_r == IDX_LAST);
      if (slot_end_s) begin
         cnt_next_s = {CW{1'b0}};
         if (idx_r == IDX_LAST) begin
            idx_next_s = {IW{1'b0}};
         end else begin
            idx_next_s = idx_r + IW'(1);
         end
      end else begin
         cnt_next_s = cnt_r + CW'(1);
         idx_next_s = idx_r;
      end
      if (wrap_s) begin
         disp_data_next_s  = shadow_data_r;
         disp_blank_next_s = shadow_blank_r;
      end else begin
         disp_data_next_s  = disp_data_r;
         disp_blank_next_s = disp_blank_r;
      end
   end

`ifdef SEG_SCAN_LZ_BLANK_EN
   logic [DIGITS-1:0] lz_s;

   // Leading-zero mask: a zero digit hides if everything above it is zero or blanked
   always_comb begin
      logic lead;
      logic zero;
      lead = 1'b1;
      zero = 1'b0;
      lz_s = {DIGITS{1'b0}};
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero    = (disp_data_next_s[4*k +: 4] == 4'h0);
         lz_s[k] = zero && lead;
         lead    = lead && (zero || disp_blank_next_s[k]);
      end
   end

   assign eff_blank_s = disp_blank_next_s | lz_s;
`else
   assign eff_blank_s = disp_blank_next_s;
`endif

   // Anode pattern for the coming cycle: dark on count 0, else bit idx unless blanked
   always_comb begin
      an_act_s = {DIGITS{1'b0}};
      for (int k = 0; k < DIGITS; k++) begin
         an_act_s[k] = (idx_next_s == IW'(k)) && !eff_blank_s[k] &&
                       (cnt_next_s != {CW{1'b0}});
      end
   end

   // Split the display register into per-digit nibbles for selection by idx
   always_comb begin
      for (int k = 0; k < DIGITS; k++) begin
         nib_arr_s[k] = disp_data_r[4*k +: 4];
      end
   end

   assign nib_s = nib_arr_s[idx_r];

   seg_hex_decode u_dec (
      .nibble   (nib_s),
      .segments (seg_dec_s)
   );

   // Slot prescaler, digit index and end-of-frame pulse
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         cnt_r        <= {CW{1'b0}};
         idx_r        <= {IW{1'b0}};
         frame_done_r <= 1'b0;
      end else begin
         cnt_r        <= cnt_next_s;
         idx_r        <= idx_next_s;
         frame_done_r <= wrap_s;
      end
   end

   // Shadow register: latest load wins
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         shadow_data_r  <= {(4*DIGITS){1'b0}};
         shadow_blank_r <= {DIGITS{1'b0}};
      end else if (load) begin
         shadow_data_r  <= data;
         shadow_blank_r <= blank;
      end else begin
         shadow_data_r  <= shadow_data_r;
         shadow_blank_r <= shadow_blank_r;
      end
   end

   // Display register: takes the shadow only at the frame wrap
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         disp_data_r  <= {(4*DIGITS){1'b0}};
         disp_blank_r <= {DIGITS{1'b0}};
      end else begin
         disp_data_r  <= disp_data_next_s;
         disp_blank_r <= disp_blank_next_s;
      end
   end

   // Registered display outputs with anode polarity applied
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         anodes_r   <= AN_OFF;
         segments_r <= 7'h00;
      end else begin
         anodes_r   <= an_act_s ^ AN_OFF;
         segments_r <= seg_dec_s;
      end
   end

   assign anodes     = anodes_r;
   assign segments   = segments_r;
   assign frame_done = frame_done_r;

endmodule
